// File: rtl/sram_req_ctrl.sv
// Single-outstanding load/store front-end for a synchronous SRAM.
// Partial-byte stores are done as read-modify-write; results go back over a valid/ready response channel.
module sram_req_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int               CNT_W    = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);
  localparam logic [ADDR_W:0]  DEPTH_W  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_reg, state_next;
  logic              we_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [3:0]        be_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] sram_addr_reg;
  logic [DATA_W-1:0] sram_wdata_reg;

  logic              out_of_range;
  logic              rd_done;
  logic [DATA_W-1:0] merged;

  assign out_of_range = ({1'b0, req_addr} >= DEPTH_W);
  assign rd_done      = (state_reg == RD) && (cnt_reg == CNT_LAST);

  // Byte-lane merge of new store data over the word just read back.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8] : sram_rdata[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (out_of_range)          state_next = RESP;
          else if (!req_we)          state_next = RD;
          else if (req_be == 4'hF)   state_next = WR;
          else if (req_be == 4'h0)   state_next = RESP;
          else                       state_next = RD;
        end
      end
      RD:      if (cnt_reg == CNT_LAST) state_next = we_reg ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      be_reg         <= '0;
      cnt_reg        <= '0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
      sram_addr_reg  <= '0;
      sram_wdata_reg <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            wdata_reg <= req_wdata;
            be_reg    <= req_be;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= out_of_range;
            // SRAM-side outputs only move for requests that will touch the array.
            if (!out_of_range && (!req_we || (req_be != 4'h0))) begin
              sram_addr_reg <= req_addr;
            end
            if (!out_of_range && req_we && (req_be == 4'hF)) begin
              sram_wdata_reg <= req_wdata;
            end
          end
        end
        RD: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (rd_done) begin
            if (we_reg) sram_wdata_reg <= merged;
            else        rdata_reg      <= sram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_reg == IDLE) && !res;
  assign rsp_valid  = (state_reg == RESP) && !res;
  assign sram_we    = (state_reg == WR) && !res;
  assign rsp_rdata  = res ? '0 : rdata_reg;
  assign rsp_err    = res ? 1'b0 : err_reg;
  assign sram_addr  = res ? '0 : sram_addr_reg;
  assign sram_wdata = res ? '0 : sram_wdata_reg;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl: SRAM model, transaction-level reference memory and per-cycle output checker.
module tb_sram_req_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 200;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              res = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [3:0]        req_be = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  always #5 clk = ~clk;

  sram_req_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .res(res),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM with one-cycle registered read; preloaded with a known pattern.
  logic        mem_init = 1'b1;
  logic [31:0] sram_mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= 32'hC0DE_0000 + 32'(i);
    end else if (sram_we) begin
      sram_mem[sram_addr] <= sram_wdata;
    end
    sram_rdata <= sram_mem[sram_addr];
  end

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ref_mem [256];
  wr_t         exp_wr_q [$];
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Per-cycle checker: reset values, every SRAM write, every response cycle.
  always @(negedge clk) begin
    if (res) begin
      check("rst_flags", 32'({req_ready, rsp_valid, rsp_err, sram_we}), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_sram_addr", 32'(sram_addr), 32'd0);
      check("rst_sram_wdata", sram_wdata, 32'd0);
    end
    if (sram_we) begin
      check("write_expected", 32'(exp_wr_q.size() != 0), 32'd1);
      if (exp_wr_q.size() != 0) begin
        wr_t w;
        w = exp_wr_q.pop_front();
        check("write_addr", 32'(sram_addr), 32'(w.a));
        check("write_data", sram_wdata, w.d);
      end
    end
    if (rsp_valid) begin
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
    end
  end

  // One transaction: model the outcome, drive it, time the response, optionally stall it.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int stall,
                        output logic [31:0] got, output logic got_err);
    int          lat;
    int          k;
    logic [31:0] nv;
    wr_t         w;
    exp_err   = (int'(addr) >= DEPTH);
    exp_rdata = '0;
    if (exp_err) begin
      lat = 1;
    end else if (!we) begin
      lat = RD_LAT + 2;
      exp_rdata = ref_mem[addr];
    end else if (be == 4'h0) begin
      lat = 1;
    end else begin
      nv = ref_mem[addr];
      for (int b = 0; b < 4; b++) if (be[b]) nv[8*b +: 8] = wdata[8*b +: 8];
      lat = (be == 4'hF) ? 2 : RD_LAT + 3;
      ref_mem[addr] = nv;
      w.a = addr;
      w.d = nv;
      exp_wr_q.push_back(w);
    end

    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1;
    rsp_ready = (stall == 0);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata; req_be = ~be;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid && k < 20);
    check("latency", 32'(k), 32'(lat));
    got = rsp_rdata;
    got_err = rsp_err;
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check("stall_hold", 32'({rsp_valid, req_ready}), 32'd2);
      check("stall_rdata", rsp_rdata, got);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("handshake_done", 32'({rsp_valid, req_ready}), 32'd1);
    check("write_drained", 32'(exp_wr_q.size()), 32'd0);
    rsp_ready = 1'b0;
    $display("req we=%0b addr=%h wdata=%h be=%h -> rdata=%h err=%0b lat=%0d", we, addr, wdata, be, got, got_err, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic        gerr;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 + 32'(i);

    repeat (3) @(posedge clk);
    #1;
    res = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    check("idle_no_rsp", 32'({rsp_valid, sram_we}), 32'd0);

    do_req(1'b1, 8'h05, 32'h0001_8000, 4'hF, 0, got, gerr);
    check("store05_rdata", got, 32'h0);
    do_req(1'b0, 8'h05, 32'h0, 4'h0, 0, got, gerr);
    check("load05_lit", got, 32'h0001_8000);

    do_req(1'b1, 8'h10, 32'hAABB_CCDD, 4'hF, 0, got, gerr);
    do_req(1'b1, 8'h10, 32'h1122_3344, 4'b0101, 0, got, gerr);
    do_req(1'b0, 8'h10, 32'h0, 4'h0, 0, got, gerr);
    check("rmw10_lit", got, 32'hAA22_CC44);

    do_req(1'b0, 8'h05, 32'h0, 4'h0, 5, got, gerr);
    check("stall_load_lit", got, 32'h0001_8000);

    do_req(1'b0, 8'hC8, 32'h0, 4'h0, 0, got, gerr);
    check("c8_err_lit", 32'({gerr, (got == 32'h0)}), 32'd3);
    do_req(1'b0, 8'hFF, 32'h0, 4'h0, 0, got, gerr);
    check("ff_err_lit", 32'(gerr), 32'd1);
    do_req(1'b1, 8'hC8, 32'h1234_5678, 4'hF, 0, got, gerr);
    do_req(1'b1, 8'h03, 32'hFFFF_FFFF, 4'h0, 0, got, gerr);
    check("be0_err_lit", 32'(gerr), 32'd0);
    do_req(1'b0, 8'h03, 32'h0, 4'h0, 0, got, gerr);
    check("load03_lit", got, 32'hC0DE_0003);

    do_req(1'b1, 8'hC7, 32'h1234_5678, 4'b1000, 2, got, gerr);
    do_req(1'b0, 8'hC7, 32'h0, 4'h0, 0, got, gerr);
    check("loadc7_lit", got, 32'h12DE_00C7);

    // Abort an RMW during its read phase: no write may follow, the word stays intact.
    req_we = 1'b1; req_addr = 8'h10; req_wdata = 32'h5566_7788; req_be = 4'b0011;
    req_valid = 1'b1;
    check("abort_accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'({rsp_valid, req_ready}), 32'd1);
    $display("abort rmw addr=10 be=3 during read phase");
    do_req(1'b0, 8'h10, 32'h0, 4'h0, 0, got, gerr);
    check("abort_keep_lit", got, 32'hAA22_CC44);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
